// File: rtl/prism_count_shift.sv
`default_nettype none
// ============================================================================
//  Module   : prism_count_shift
//  Purpose  : Countdown / event counter / comm shift engine for PRISM
//             peripherals, with auto-reload and a maskable sticky interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module prism_count_shift #(
    parameter int C1_W = 24,
    parameter int C2_W = 8,
    parameter int SH_W = 8,
    parameter int SC_W = $clog2(C1_W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exec_i,
    input  logic            dec_i,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic            clr_i,
    input  logic            shift_i,
    input  logic            serial_in_i,
    input  logic [C1_W-1:0] cfg_preload_i,
    input  logic [C2_W-1:0] cfg_compare_i,
    input  logic            cfg_shift_dir_i,
    input  logic            cfg_shift_wide_i,
    input  logic [SC_W-1:0] cfg_shift_len_i,
    input  logic            cfg_autoreload_i,
    input  logic [2:0]      cfg_irq_en_i,
    input  logic            host_wr_i,
    input  logic [SH_W-1:0] host_wdata_i,
    input  logic            irq_clr_i,
    output logic [C1_W-1:0] count1_o,
    output logic [C2_W-1:0] count2_o,
    output logic [SH_W-1:0] shreg_o,
    output logic            serial_out_o,
    output logic            c1_zero_o,
    output logic            c2_match_o,
    output logic            sc_zero_o,
    output logic            word_done_o,
    output logic            irq_o
);

    logic [C1_W-1:0] count1_q, count1_d;
    logic [C2_W-1:0] count2_q, count2_d;
    logic [SH_W-1:0] shreg_q, shreg_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic            word_done_q, word_done_d;
    logic            irq_q, irq_d;

    logic w_dec, w_load, w_inc, w_clr, w_shift;
    logic w_ev_cd, w_ev_sw;

    assign w_dec   = exec_i & dec_i;
    assign w_load  = exec_i & load_i;
    assign w_inc   = exec_i & inc_i;
    assign w_clr   = exec_i & clr_i;
    assign w_shift = exec_i & shift_i;

    // Expiry fires on the 1->0 step, or on every auto-reload from 0.
    assign w_ev_cd = w_dec & ~w_load &
                     ((count1_q == C1_W'(1)) | ((count1_q == '0) & cfg_autoreload_i));
    assign w_ev_sw = w_clr & w_inc;

    always_comb begin
        count1_d = count1_q;
        if (w_load && !w_dec) begin
            count1_d = cfg_preload_i;
        end else if (w_dec && !w_load) begin
            if (count1_q != '0)
                count1_d = count1_q - C1_W'(1);
            else if (cfg_autoreload_i)
                count1_d = cfg_preload_i;
        end else if (w_shift && cfg_shift_wide_i) begin
            count1_d = {count1_q[C1_W-2:0], serial_in_i};
        end else if (w_load && w_dec) begin
            count1_d[SH_W-1:0] = shreg_q;
        end
    end

    always_comb begin
        count2_d = count2_q;
        if (w_clr && !w_inc)
            count2_d = '0;
        else if (w_inc && !w_clr)
            count2_d = count2_q + C2_W'(1);
    end

    always_comb begin
        shreg_d = shreg_q;
        if (host_wr_i)
            shreg_d = host_wdata_i;
        else if (w_shift && !cfg_shift_wide_i)
            shreg_d = cfg_shift_dir_i ? {serial_in_i, shreg_q[SH_W-1:1]}
                                      : {shreg_q[SH_W-2:0], serial_in_i};
    end

    always_comb begin
        sc_d        = sc_q;
        word_done_d = 1'b0;
        if (w_shift) begin
            if (sc_q == cfg_shift_len_i) begin
                sc_d        = '0;
                word_done_d = 1'b1;
            end else begin
                sc_d = sc_q + SC_W'(1);
            end
        end
    end

    always_comb begin
        irq_d = irq_q;
        if ((w_ev_cd & cfg_irq_en_i[0]) | (word_done_d & cfg_irq_en_i[1]) |
            (w_ev_sw & cfg_irq_en_i[2]))
            irq_d = 1'b1;
        else if (irq_clr_i)
            irq_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count1_q    <= '0;
            count2_q    <= '0;
            shreg_q     <= '0;
            sc_q        <= '0;
            word_done_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            count1_q    <= count1_d;
            count2_q    <= count2_d;
            shreg_q     <= shreg_d;
            sc_q        <= sc_d;
            word_done_q <= word_done_d;
            irq_q       <= irq_d;
        end
    end

    assign count1_o     = count1_q;
    assign count2_o     = count2_q;
    assign shreg_o      = shreg_q;
    assign word_done_o  = word_done_q;
    assign irq_o        = irq_q;
    assign c1_zero_o    = (count1_q == '0);
    assign c2_match_o   = (count2_q == cfg_compare_i);
    assign sc_zero_o    = (sc_q == '0);
    assign serial_out_o = cfg_shift_wide_i ? count1_q[C1_W-1]
                        : (cfg_shift_dir_i ? shreg_q[0] : shreg_q[SH_W-1]);

endmodule
`default_nettype wire

// File: tb/tb_prism_count_shift.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prism_count_shift
//  Purpose  : Directed scenarios plus randomized traffic against a
//             behavioural model of prism_count_shift.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prism_count_shift;

    localparam int C1_W = 24;
    localparam int C2_W = 8;
    localparam int SH_W = 8;
    localparam int SC_W = $clog2(C1_W) + 1;
    localparam int unsigned C1_MOD = 1 << C1_W;
    localparam int unsigned C2_MOD = 1 << C2_W;
    localparam int unsigned SH_MOD = 1 << SH_W;
    localparam int unsigned SC_MOD = 1 << SC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exec_i = 1'b0, dec_i = 1'b0, load_i = 1'b0, inc_i = 1'b0, clr_i = 1'b0;
    logic shift_i = 1'b0, serial_in_i = 1'b0;
    logic [C1_W-1:0] cfg_preload_i = '0;
    logic [C2_W-1:0] cfg_compare_i = '0;
    logic cfg_shift_dir_i = 1'b0, cfg_shift_wide_i = 1'b0, cfg_autoreload_i = 1'b0;
    logic [SC_W-1:0] cfg_shift_len_i = '0;
    logic [2:0] cfg_irq_en_i = '0;
    logic host_wr_i = 1'b0;
    logic [SH_W-1:0] host_wdata_i = '0;
    logic irq_clr_i = 1'b0;
    logic [C1_W-1:0] count1_o;
    logic [C2_W-1:0] count2_o;
    logic [SH_W-1:0] shreg_o;
    logic serial_out_o, c1_zero_o, c2_match_o, sc_zero_o, word_done_o, irq_o;

    prism_count_shift #(.C1_W(C1_W), .C2_W(C2_W), .SH_W(SH_W), .SC_W(SC_W)) u_dut (
        .clk(clk), .rst(rst), .exec_i(exec_i), .dec_i(dec_i), .load_i(load_i),
        .inc_i(inc_i), .clr_i(clr_i), .shift_i(shift_i), .serial_in_i(serial_in_i),
        .cfg_preload_i(cfg_preload_i), .cfg_compare_i(cfg_compare_i),
        .cfg_shift_dir_i(cfg_shift_dir_i), .cfg_shift_wide_i(cfg_shift_wide_i),
        .cfg_shift_len_i(cfg_shift_len_i), .cfg_autoreload_i(cfg_autoreload_i),
        .cfg_irq_en_i(cfg_irq_en_i), .host_wr_i(host_wr_i), .host_wdata_i(host_wdata_i),
        .irq_clr_i(irq_clr_i), .count1_o(count1_o), .count2_o(count2_o), .shreg_o(shreg_o),
        .serial_out_o(serial_out_o), .c1_zero_o(c1_zero_o), .c2_match_o(c2_match_o),
        .sc_zero_o(sc_zero_o), .word_done_o(word_done_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_c1, m_c2, m_sh, m_sc;
    bit m_wd, m_irq;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c1 = 0; m_c2 = 0; m_sh = 0; m_sc = 0; m_wd = 0; m_irq = 0;
    endtask

    // Next state from the current inputs; called right after the rising edge.
    task automatic model_update();
        bit d, l, in_, cl, s, ev_cd, ev_wd, ev_sw;
        int unsigned c1n, c2n, shn, scn;
        d = exec_i & dec_i; l = exec_i & load_i; in_ = exec_i & inc_i;
        cl = exec_i & clr_i; s = exec_i & shift_i;
        ev_cd = 0; ev_wd = 0; ev_sw = 0;
        c1n = m_c1; c2n = m_c2; shn = m_sh; scn = m_sc;
        if (l && !d) c1n = cfg_preload_i;
        else if (d && !l) begin
            if (m_c1 != 0) begin c1n = m_c1 - 1; ev_cd = (m_c1 == 1); end
            else if (cfg_autoreload_i) begin c1n = cfg_preload_i; ev_cd = 1; end
        end
        else if (s && cfg_shift_wide_i) c1n = (m_c1 * 2 + serial_in_i) % C1_MOD;
        else if (l && d) c1n = (m_c1 / SH_MOD) * SH_MOD + m_sh;
        if (cl && !in_) c2n = 0;
        else if (in_ && !cl) c2n = (m_c2 + 1) % C2_MOD;
        else if (cl && in_) ev_sw = 1;
        if (host_wr_i) shn = host_wdata_i;
        else if (s && !cfg_shift_wide_i)
            shn = cfg_shift_dir_i ? (serial_in_i * (SH_MOD / 2) + m_sh / 2)
                                  : ((m_sh * 2 + serial_in_i) % SH_MOD);
        if (s) begin
            if (m_sc == cfg_shift_len_i) begin scn = 0; ev_wd = 1; end
            else scn = (m_sc + 1) % SC_MOD;
        end
        if ((ev_cd && cfg_irq_en_i[0]) || (ev_wd && cfg_irq_en_i[1]) || (ev_sw && cfg_irq_en_i[2]))
            m_irq = 1;
        else if (irq_clr_i) m_irq = 0;
        m_c1 = c1n; m_c2 = c2n; m_sh = shn; m_sc = scn; m_wd = ev_wd;
    endtask

    task automatic check_all();
        bit so;
        if (cfg_shift_wide_i) so = (m_c1 >> (C1_W - 1)) & 1;
        else if (cfg_shift_dir_i) so = m_sh & 1;
        else so = (m_sh >> (SH_W - 1)) & 1;
        check_eq("count1", 32'(count1_o), m_c1);
        check_eq("count2", 32'(count2_o), m_c2);
        check_eq("shreg", 32'(shreg_o), m_sh);
        check_eq("serial_out", 32'(serial_out_o), 32'(so));
        check_eq("c1_zero", 32'(c1_zero_o), 32'(m_c1 == 0));
        check_eq("c2_match", 32'(c2_match_o), 32'(m_c2 == cfg_compare_i));
        check_eq("sc_zero", 32'(sc_zero_o), 32'(m_sc == 0));
        check_eq("word_done", 32'(word_done_o), 32'(m_wd));
        check_eq("irq", 32'(irq_o), 32'(m_irq));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle();
        exec_i = 1; dec_i = 0; load_i = 0; inc_i = 0; clr_i = 0; shift_i = 0;
        host_wr_i = 0; irq_clr_i = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count1"}, 32'(count1_o), 0);
        check_eq({tag, "_count2"}, 32'(count2_o), 0);
        check_eq({tag, "_shreg"}, 32'(shreg_o), 0);
        check_eq({tag, "_serial_out"}, 32'(serial_out_o), 0);
        check_eq({tag, "_word_done"}, 32'(word_done_o), 0);
        check_eq({tag, "_irq"}, 32'(irq_o), 0);
        check_eq({tag, "_sc_zero"}, 32'(sc_zero_o), 1);
    endtask

    initial begin
        logic [7:0] pat;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;
        idle();

        // Countdown from 3 with expiry interrupt.
        cfg_preload_i = 24'd3; cfg_irq_en_i = 3'b001;
        load_i = 1; step(); load_i = 0;
        check_eq("cd_load", 32'(count1_o), 3);
        dec_i = 1;
        step(); check_eq("cd_2", 32'(count1_o), 2);
        step(); check_eq("cd_1", 32'(count1_o), 1);
        check_eq("cd_irq_early", 32'(irq_o), 0);
        step(); check_eq("cd_0", 32'(count1_o), 0);
        check_eq("cd_irq", 32'(irq_o), 1);
        irq_clr_i = 1; step(); irq_clr_i = 0;
        check_eq("cd_hold0", 32'(count1_o), 0);
        check_eq("cd_no_reevent", 32'(irq_o), 0);
        cfg_autoreload_i = 1; step();
        check_eq("cd_reload", 32'(count1_o), 3);
        check_eq("cd_reload_irq", 32'(irq_o), 1);
        dec_i = 0; cfg_autoreload_i = 0; irq_clr_i = 1; step(); irq_clr_i = 0;

        // Comm shift of 0xA5, MSB first.
        host_wr_i = 1; host_wdata_i = 8'hA5; step(); host_wr_i = 0;
        cfg_shift_len_i = 6'd7; cfg_shift_dir_i = 0; serial_in_i = 0; shift_i = 1;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check_eq("comm_bit", 32'(serial_out_o), 32'(pat[7-i]));
            check_eq("comm_wd_early", 32'(word_done_o), 0);
            step();
        end
        check_eq("comm_shreg", 32'(shreg_o), 0);
        check_eq("comm_wd", 32'(word_done_o), 1);
        check_eq("comm_sc_zero", 32'(sc_zero_o), 1);
        shift_i = 0; step();
        check_eq("comm_wd_once", 32'(word_done_o), 0);

        // Wide shift of 24 ones into count1.
        host_wr_i = 1; host_wdata_i = 8'h5A; step(); host_wr_i = 0;
        cfg_shift_wide_i = 1; serial_in_i = 1; shift_i = 1;
        repeat (24) step();
        shift_i = 0; step();
        check_eq("wide_c1", 32'(count1_o), 32'hFFFFFF);
        check_eq("wide_shreg", 32'(shreg_o), 32'h5A);
        cfg_shift_wide_i = 0;

        // Event counter.
        cfg_compare_i = 8'd5; clr_i = 1; step(); clr_i = 0;
        inc_i = 1; repeat (5) step(); inc_i = 0;
        check_eq("ev_match", 32'(c2_match_o), 1);
        inc_i = 1; repeat (251) step(); inc_i = 0;
        check_eq("ev_wrap", 32'(count2_o), 0);
        cfg_irq_en_i = 3'b100; irq_clr_i = 1; step(); irq_clr_i = 0;
        check_eq("ev_irq_cleared", 32'(irq_o), 0);
        inc_i = 1; step(); clr_i = 1; step();
        check_eq("ev_sw_hold", 32'(count2_o), 1);
        check_eq("ev_sw_irq", 32'(irq_o), 1);
        irq_clr_i = 1; step(); irq_clr_i = 0; inc_i = 0; clr_i = 0;
        check_eq("ev_set_wins", 32'(irq_o), 1);

        // load & dec merges shreg into the low byte.
        cfg_preload_i = 24'h123456; load_i = 1; step();
        host_wr_i = 1; host_wdata_i = 8'h3C; load_i = 0; step(); host_wr_i = 0;
        load_i = 1; dec_i = 1; step(); load_i = 0; dec_i = 0;
        check_eq("ld_dec", 32'(count1_o), 32'h12343C);

        // Asynchronous reset mid-word.
        shift_i = 1; repeat (3) step(); shift_i = 0;
        check_eq("pre_rst_irq", 32'(irq_o), 1);
        check_eq("pre_rst_sc", 32'(sc_zero_o), 0);
        #2 rst = 1;
        #1 model_reset();
        check_reset_outputs("async_rst");
        @(negedge clk); rst = 0;
        inc_i = 1; step(); inc_i = 0;
        check_eq("post_rst_inc", 32'(count2_o), 1);

        // Randomized traffic.
        for (int blk = 0; blk < 40; blk++) begin
            cfg_preload_i    = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 5));
            cfg_compare_i    = 8'($urandom_range(0, 6));
            cfg_shift_len_i  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            cfg_shift_dir_i  = 1'($urandom);
            cfg_shift_wide_i = 1'($urandom);
            cfg_autoreload_i = 1'($urandom);
            cfg_irq_en_i     = 3'($urandom);
            for (int c = 0; c < 40; c++) begin
                exec_i      = ($urandom_range(0, 4) != 0);
                dec_i       = 1'($urandom); load_i = ($urandom_range(0, 5) == 0);
                inc_i       = 1'($urandom); clr_i = ($urandom_range(0, 3) == 0);
                shift_i     = 1'($urandom); serial_in_i = 1'($urandom);
                host_wr_i   = ($urandom_range(0, 9) == 0); host_wdata_i = 8'($urandom);
                irq_clr_i   = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        idle();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
